cache_trace_gen: RTL
====================

CACHE_TRACE_GEN -- requirements
Module: cache_trace_gen

Interface
REQ-001 SHALL have parameter LINE_SIZE, default 32, cache line size in bytes.
REQ-002 SHALL have parameter SECTOR_SIZE, default 8, sector size in bytes, power of 2.
REQ-003 SHALL have parameter SEQ_SPAN, default 1000, byte span of the sequential pattern.
REQ-004 SHALL have parameter NUM_RAND, default 1000, number of random accesses.
REQ-005 SHALL have parameter RAND_RANGE, default 65536, random address range in bytes, power of 2.
REQ-006 SHALL have parameter NUM_REUSE, default 1000, number of sector-reuse accesses.
REQ-007 SHALL have parameter REUSE_PERIOD, default 100, accesses per line in the reuse pattern.
REQ-008 SHALL have parameter LFSR_SEED, default 32'hACE1_2468, non-zero LFSR reset value.
REQ-009 SHALL have port list: clk in 1, rising-edge clock; rst_n in 1, reset.
REQ-010 SHALL have port start in 1, run request, sampled only in IDLE or DONE.
REQ-011 SHALL have port mode in 2, pattern select: 0 seq, 1 random, 2 sector reuse, 3 seq->random->reuse; sampled with start.
REQ-012 SHALL have port addr out 32, access address driven to the cache.
REQ-013 SHALL have port addr_valid out 1, addr carries a generated access this cycle.
REQ-014 SHALL have ports hit in 1 and miss in 1, registered cache response.
REQ-015 SHALL have ports busy out 1 and done out 1.
REQ-016 SHALL have ports gen_count out 32, obs_hits out 32, obs_misses out 32, and err_protocol out 1.
REQ-017 SHALL use one clock (clk); reset rst_n is synchronous and active-low.

Function
REQ-018 SHALL use states IDLE, SEQ, RAND, REUSE, DRAIN, DONE, with all outputs registered.
REQ-019 Start handling: start=1 in IDLE/DONE SHALL, on that edge, clear gen_count/obs counters/err_protocol, enter the first state of mode, and present the first address with addr_valid=1. start SHALL be ignored in any other state.
REQ-020 SEQ SHALL issue addr = i*SECTOR_SIZE for i = 0.. while addr < SEQ_SPAN, giving ceil(SEQ_SPAN/SECTOR_SIZE) accesses (125 at defaults), one per cycle.
REQ-021 RAND SHALL advance a 32-bit Galois LFSR (taps 0x80200003) once per access and issue addr = lfsr & (RAND_RANGE-1), for NUM_RAND accesses.
REQ-022 REUSE SHALL issue addr = base + (i mod (LINE_SIZE/SECTOR_SIZE))*SECTOR_SIZE, with base starting at 0 and base += LINE_SIZE after every REUSE_PERIOD-th access; NUM_REUSE accesses.
REQ-023 Mode 3 SHALL chain SEQ->RAND->REUSE back-to-back with no idle cycle between patterns.
REQ-024 Completion: after the last access of the run, SHALL enter DRAIN (addr_valid=0, addr holds last value) for one cycle, then enter DONE.
REQ-025 gen_count SHALL increment on every cycle with addr_valid=1, wrapping at 2^32.
REQ-026 Response tracking: resp_pending SHALL be addr_valid delayed by one cycle; hit/miss SHALL be sampled only when resp_pending=1, including in DRAIN.
REQ-027 busy SHALL be 1 in SEQ/RAND/REUSE/DRAIN; done SHALL be 1 only in DONE, held until start or reset.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE and LFSR=LFSR_SEED, and SHALL clear addr, addr_valid, busy, done, gen_count, obs_hits, obs_misses, err_protocol, resp_pending, and the pattern indices, including mid-run.
REQ-029 Reset SHALL take priority over start.

Configuration
REQ-030 Macro TRACE_GEN_STATS_EN defined: on a resp_pending cycle, hit=1,miss=0 SHALL increment obs_hits; hit=0,miss=1 SHALL increment obs_misses; hit==miss SHALL set err_protocol sticky and increment neither counter.
REQ-031 Macro TRACE_GEN_STATS_EN undefined: obs_hits, obs_misses, and err_protocol SHALL be constant 0, and no counter logic SHALL be built.

Verification
REQ-032 Mode 0 at defaults, start pulse at edge k: addr_valid high for edges k..k+124 with addr 0,8,...,992; DRAIN at k+125; done=1 from k+126; gen_count=125.
REQ-033 Mode 2 at defaults: accesses 0-99 cycle addr 0,8,16,24; access 100 addr=32; final access 999 addr=9*32+24=312; gen_count=1000.
REQ-034 Mode 3 at defaults with a cache model always returning miss: gen_count=2125, obs_misses=2125, obs_hits=0, err_protocol=0.
REQ-035 Drive hit=1,miss=1 on one resp_pending cycle: err_protocol=1 and held until next start; that cycle counted in neither obs counter.
REQ-036 rst_n=0 at access 50 of mode 1, then restart mode 1: first random address is identical to that of the first run; start asserted while busy has no effect.

Source files
------------

// File: rtl/cache_trace_gen.sv
// Cache access trace generator: sequential, LFSR-random and sector-reuse address patterns,
// with optional hit/miss statistics enabled by defining TRACE_GEN_STATS_EN.
module cache_trace_gen #(
  parameter int unsigned LINE_SIZE    = 32,
  parameter int unsigned SECTOR_SIZE  = 8,
  parameter int unsigned SEQ_SPAN     = 1000,
  parameter int unsigned NUM_RAND     = 1000,
  parameter int unsigned RAND_RANGE   = 65536,
  parameter int unsigned NUM_REUSE    = 1000,
  parameter int unsigned REUSE_PERIOD = 100,
  parameter logic [31:0] LFSR_SEED    = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  mode,
  output logic [31:0] addr,
  output logic        addr_valid,
  input  logic        hit,
  input  logic        miss,
  output logic        busy,
  output logic        done,
  output logic [31:0] gen_count,
  output logic [31:0] obs_hits,
  output logic [31:0] obs_misses,
  output logic        err_protocol
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEQ   = 3'd1;
  localparam logic [2:0] S_RAND  = 3'd2;
  localparam logic [2:0] S_REUSE = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
  localparam logic [31:0] SECTOR_B    = 32'(SECTOR_SIZE);
  localparam logic [31:0] LINE_B      = 32'(LINE_SIZE);
  localparam logic [31:0] SEQ_SPAN_B  = 32'(SEQ_SPAN);
  localparam logic [31:0] RAND_MASK   = 32'(RAND_RANGE - 1);
  localparam logic [31:0] NUM_RAND_B  = 32'(NUM_RAND);
  localparam logic [31:0] NUM_REUSE_B = 32'(NUM_REUSE);
  localparam logic [31:0] PERIOD_LAST = 32'(REUSE_PERIOD - 1);
  localparam logic [31:0] SUB_LAST    = 32'(LINE_SIZE / SECTOR_SIZE - 1);

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
  endfunction

  logic [2:0]  r_state, w_state;
  logic [31:0] r_addr, w_addr;
  logic        r_addr_valid, w_addr_valid;
  logic        r_busy, r_done;
  logic [31:0] r_gen_count, w_gen_count;
  logic        r_resp_pending;
  logic [31:0] r_lfsr, w_lfsr;
  logic [31:0] r_idx, w_idx;
  logic [31:0] r_sub, w_sub;
  logic [31:0] r_per, w_per;
  logic [31:0] r_base, w_base;
  logic        r_chain, w_chain;
  logic        w_clr;
  logic [2:0]  w_enter;

  // Next-state: per-pattern advance, then a common "enter pattern" step for the first access
  always_comb begin
    w_state      = r_state;
    w_addr       = r_addr;
    w_addr_valid = 1'b0;
    w_lfsr       = r_lfsr;
    w_idx        = r_idx;
    w_sub        = r_sub;
    w_per        = r_per;
    w_base       = r_base;
    w_chain      = r_chain;
    w_gen_count  = r_addr_valid ? r_gen_count + 32'd1 : r_gen_count;
    w_clr        = 1'b0;
    w_enter      = S_IDLE;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_clr       = 1'b1;
          w_gen_count = '0;
          w_chain     = (mode == 2'd3);
          case (mode)
            2'd1:    w_enter = S_RAND;
            2'd2:    w_enter = S_REUSE;
            default: w_enter = S_SEQ;
          endcase
        end
      end
      S_SEQ: begin
        if (r_addr + SECTOR_B < SEQ_SPAN_B) begin
          w_addr       = r_addr + SECTOR_B;
          w_addr_valid = 1'b1;
        end else begin
          w_enter = r_chain ? S_RAND : S_DRAIN;
        end
      end
      S_RAND: begin
        if (r_idx < NUM_RAND_B) begin
          w_lfsr       = lfsr_step(r_lfsr);
          w_addr       = w_lfsr & RAND_MASK;
          w_addr_valid = 1'b1;
          w_idx        = r_idx + 32'd1;
        end else begin
          w_enter = r_chain ? S_REUSE : S_DRAIN;
        end
      end
      S_REUSE: begin
        if (r_idx < NUM_REUSE_B) begin
          w_sub        = (r_sub == SUB_LAST) ? 32'd0 : r_sub + 32'd1;
          w_per        = (r_per == PERIOD_LAST) ? 32'd0 : r_per + 32'd1;
          w_base       = (r_per == PERIOD_LAST) ? r_base + LINE_B : r_base;
          w_addr       = w_base + w_sub * SECTOR_B;
          w_addr_valid = 1'b1;
          w_idx        = r_idx + 32'd1;
        end else begin
          w_enter = S_DRAIN;
        end
      end
      S_DRAIN: w_state = S_DONE;
      default: w_state = S_IDLE;
    endcase

    case (w_enter)
      S_SEQ: begin
        w_state      = S_SEQ;
        w_addr       = '0;
        w_addr_valid = 1'b1;
      end
      S_RAND: begin
        w_state      = S_RAND;
        w_lfsr       = lfsr_step(r_lfsr);
        w_addr       = w_lfsr & RAND_MASK;
        w_addr_valid = 1'b1;
        w_idx        = 32'd1;
      end
      S_REUSE: begin
        w_state      = S_REUSE;
        w_addr       = '0;
        w_addr_valid = 1'b1;
        w_idx        = 32'd1;
        w_sub        = '0;
        w_per        = '0;
        w_base       = '0;
      end
      S_DRAIN: w_state = S_DRAIN;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_addr         <= '0;
      r_addr_valid   <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_gen_count    <= '0;
      r_resp_pending <= 1'b0;
      r_lfsr         <= LFSR_SEED;
      r_idx          <= '0;
      r_sub          <= '0;
      r_per          <= '0;
      r_base         <= '0;
      r_chain        <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_addr         <= w_addr;
      r_addr_valid   <= w_addr_valid;
      r_busy         <= (w_state == S_SEQ) || (w_state == S_RAND) ||
                        (w_state == S_REUSE) || (w_state == S_DRAIN);
      r_done         <= (w_state == S_DONE);
      r_gen_count    <= w_gen_count;
      r_resp_pending <= r_addr_valid;
      r_lfsr         <= w_lfsr;
      r_idx          <= w_idx;
      r_sub          <= w_sub;
      r_per          <= w_per;
      r_base         <= w_base;
      r_chain        <= w_chain;
    end
  end

  assign addr       = r_addr;
  assign addr_valid = r_addr_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign gen_count  = r_gen_count;

`ifdef TRACE_GEN_STATS_EN
  logic [31:0] r_obs_hits, w_obs_hits;
  logic [31:0] r_obs_misses, w_obs_misses;
  logic        r_err, w_err;

  // Response classification; hit==miss is a protocol violation and is not counted
  always_comb begin
    w_obs_hits   = r_obs_hits;
    w_obs_misses = r_obs_misses;
    w_err        = r_err;
    if (w_clr) begin
      w_obs_hits   = '0;
      w_obs_misses = '0;
      w_err        = 1'b0;
    end else if (r_resp_pending) begin
      if (hit && !miss)      w_obs_hits   = r_obs_hits + 32'd1;
      else if (!hit && miss) w_obs_misses = r_obs_misses + 32'd1;
      else                   w_err        = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_obs_hits   <= '0;
      r_obs_misses <= '0;
      r_err        <= 1'b0;
    end else begin
      r_obs_hits   <= w_obs_hits;
      r_obs_misses <= w_obs_misses;
      r_err        <= w_err;
    end
  end

  assign obs_hits     = r_obs_hits;
  assign obs_misses   = r_obs_misses;
  assign err_protocol = r_err;
`else
  logic w_unused;
  assign w_unused     = &{1'b0, hit, miss, r_resp_pending, w_clr};
  assign obs_hits     = '0;
  assign obs_misses   = '0;
  assign err_protocol = 1'b0;
`endif

endmodule
